fifo_pong_arbiter: RTL and testbench
====================================

# fifo_pong_arbiter

Two-requester round-robin arbiter that shares the single enqueue method of a ping-pong FIFO (704-bit payload, `Fifo1` element pair) between two producers. It presents two method-style enqueue ports upstream and drives the FIFO's `in$enq` method through a one-entry registered output stage. The block sits directly in front of the ping-pong FIFO instance, so neither producer sees the other's traffic and neither can be starved.

## Interface
- `WIDTH`, 704: payload width; must match the FIFO's `enq_v` width.
- `STAT_W`, 16: width of the statistics counters (used only with `FIFO_PONG_ARB_STATS_EN`).

Ports:
- `CLK`  in  1  sole clock; all state updates on posedge.
- `nRST`  in  1  reset; synchronous, active-low.
- `req0$pending`  in  1  requester 0 holds a beat it wants to enqueue (level).
- `req0$enq__ENA`  in  1  requester 0 enqueue strobe.
- `req0$enq_v`  in  WIDTH  requester 0 payload.
- `req0$enq__RDY`  out  1  requester 0 may enqueue this cycle.
- `req1$pending`, `req1$enq__ENA`, `req1$enq_v`, `req1$enq__RDY`: same as requester 0.
- `fifo$enq__ENA`  out  1  enqueue strobe to the FIFO.
- `fifo$enq_v`  out  WIDTH  payload to the FIFO.
- `fifo$enq__RDY`  in  1  FIFO can accept.
- `stat$grant0`, `stat$grant1`  out  STAT_W  accepted-beat counts (macro only).
- `stat$stall`  out  STAT_W  downstream back-pressure cycles (macro only).

## Operation
- State: `out_valid` (1), `out_data` (WIDTH), `last_grant` (1).
- `drain = out_valid & fifo$enq__RDY`; `accept = !out_valid | fifo$enq__RDY`.
- Pick: only one requester pending → that requester; both pending → `!last_grant`; neither → no grant.
- `reqN$enq__RDY = accept & pending_N & (pick == N)`; combinational; it never depends on `reqN$enq__ENA`.
- Internal enable `reqN_ena = reqN$enq__ENA & reqN$enq__RDY`. An ENA without RDY is ignored and has no side effect.
- At most one `reqN_ena` per cycle, guaranteed by the pick.
- On `reqN_ena`: `out_data <= reqN$enq_v`, `out_valid <= 1`, `last_grant <= N`.
- On `drain` without any `reqN_ena`: `out_valid <= 0`.
- Drain and accept in the same cycle: `out_valid` stays 1 and `out_data` is replaced.
- `fifo$enq__ENA = out_valid`; `fifo$enq_v = out_data`.
- `last_grant` changes only on an accepted beat. A grant that the requester does not take leaves the priority unchanged.
- Pending with ENA never asserted holds the grant indefinitely; this is the producer's contract, not an arbiter fault.

## Timing
- Reset values: `out_valid = 0`, `fifo$enq__ENA = 0`, `out_data = 0`, `last_grant = 1` (requester 0 wins the first tie); both `reqN$enq__RDY = 0` until pending is seen; all counters 0.
- Latency: 1 cycle from accepted `reqN$enq__ENA` to `fifo$enq__ENA`.
- Throughput: 1 beat/cycle while `fifo$enq__RDY = 1`. Beats from both requesters alternate strictly when both are continuously pending.
- Back-pressure: while `out_valid & !fifo$enq__RDY`, both RDYs are 0 and `out_data` is held stable.
- Reset asserted mid-transfer drops the held beat. No ENA is issued in the reset cycle or the cycle after.

## Configuration
- `FIFO_PONG_ARB_STATS_EN` defined:
  - `stat$grant0` / `stat$grant1` increment on `req0_ena` / `req1_ena`.
  - `stat$stall` increments each cycle `out_valid & !fifo$enq__RDY`.
  - All three saturate at `2^STAT_W-1` and clear on reset.
- Undefined: the `stat$*` ports and counters are absent; arbitration behaviour is identical.

## Structure
- Package `fifo_pong_arb_pkg`:
  - `FIFO_PONG_ARB_WIDTH = 704`, `FIFO_PONG_ARB_STAT_W = 16`.
  - Typedef `payload_t`.
  - Source-id enum `SRC_REQ0` / `SRC_REQ1`.
- Sub-module `arb_rr2`: combinational two-way round-robin pick from (`pending0`, `pending1`, `last_grant`). Reusable by other two-producer front ends.

## Test plan
- Reset, req0 pending, payload 0x...A5, FIFO ready → `req0$enq__RDY = 1`, `fifo$enq__ENA = 1` with 0x...A5 exactly one cycle later.
- Both pending continuously for 8 cycles, FIFO always ready → grants 0,1,0,1,0,1,0,1; FIFO sees an interleaved stream with no bubbles.
- Beat held, FIFO ready held low 5 cycles → `fifo$enq_v` stable, both RDYs 0, no beat lost; with macro, `stat$stall = 5`.
- req1 granted but ENA withheld 3 cycles, then given → `last_grant` unchanged until accept; the next tie goes to req0.
- Drain and accept in the same cycle (FIFO ready, req0 ENA) → `out_valid` stays 1, new payload appears next cycle, old payload enqueued once.
- `nRST` low while `out_valid = 1` → `fifo$enq__ENA = 0` next cycle; counters 0; first tie after reset goes to req0.

Source files
------------

// File: rtl/fifo_pong_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pong_arb_pkg
// Shared types and constants for the two-producer front end of the ping-pong
// FIFO enqueue method.
//   FIFO_PONG_ARB_WIDTH  : payload width (matches the FIFO enq_v width)
//   FIFO_PONG_ARB_STAT_W : statistics counter width (FIFO_PONG_ARB_STATS_EN)
//   payload_t            : one enqueue beat
//   src_e                : requester id, also the encoding of last_grant
// -----------------------------------------------------------------------------
package fifo_pong_arb_pkg;

    localparam int FIFO_PONG_ARB_WIDTH  = 704;
    localparam int FIFO_PONG_ARB_STAT_W = 16;

    typedef logic [FIFO_PONG_ARB_WIDTH-1:0] payload_t;

    typedef enum logic {
        SRC_REQ0 = 1'b0,
        SRC_REQ1 = 1'b1
    } src_e;

    // The requester that is not the given one; used to rotate priority on a tie.
    function automatic src_e other_src(input src_e s);
        src_e r;
        case (s)
            SRC_REQ0: r = SRC_REQ1;
            SRC_REQ1: r = SRC_REQ0;
            default:  r = SRC_REQ0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fifo_pong_arbiter_arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Combinational two-way round-robin pick. A lone pending requester always
// wins; on a tie the requester that was not granted last wins.
// Ports:
//   i_pending0 / i_pending1 : requester has a beat waiting
//   i_last_grant            : id of the last requester whose beat was accepted
//   o_valid                 : some requester is picked
//   o_pick                  : id of the picked requester (SRC_REQ0 when !o_valid)
// -----------------------------------------------------------------------------
module arb_rr2
    import fifo_pong_arb_pkg::*;
(
    input  logic i_pending0,
    input  logic i_pending1,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_pick
);

    // Pick decode from the two pending levels and the rotation state.
    always_comb begin
        o_valid = 1'b0;
        o_pick  = SRC_REQ0;
        case ({i_pending1, i_pending0})
            2'b01: begin
                o_valid = 1'b1;
                o_pick  = SRC_REQ0;
            end
            2'b10: begin
                o_valid = 1'b1;
                o_pick  = SRC_REQ1;
            end
            2'b11: begin
                o_valid = 1'b1;
                o_pick  = other_src(src_e'(i_last_grant));
            end
            default: begin
                o_valid = 1'b0;
                o_pick  = SRC_REQ0;
            end
        endcase
    end

endmodule

// File: rtl/fifo_pong_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_pong_arbiter
// Shares the single enqueue method of a ping-pong FIFO between two producers
// through a one-entry registered output stage, with round-robin priority so
// neither producer can starve the other.
// Optional feature macro: FIFO_PONG_ARB_STATS_EN (adds STAT_W and the stat_*
// saturating counters; arbitration is identical either way).
// Ports:
//   CLK, nRST                       : clock, synchronous active-low reset
//   reqN_pending                    : requester N holds a beat (level)
//   reqN_enq__ENA / reqN_enq_v      : requester N enqueue strobe / payload
//   reqN_enq__RDY                   : requester N may enqueue this cycle
//   fifo_enq__ENA / fifo_enq_v      : enqueue strobe / payload to the FIFO
//   fifo_enq__RDY                   : FIFO can accept
//   stat_grant0/1, stat_stall       : accepted beats / back-pressure cycles
// -----------------------------------------------------------------------------
module fifo_pong_arbiter
    import fifo_pong_arb_pkg::*;
#(
    parameter int WIDTH  = FIFO_PONG_ARB_WIDTH
`ifdef FIFO_PONG_ARB_STATS_EN
   ,parameter int STAT_W = FIFO_PONG_ARB_STAT_W
`endif
)(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             req0_pending,
    input  logic             req0_enq__ENA,
    input  logic [WIDTH-1:0] req0_enq_v,
    output logic             req0_enq__RDY,
    input  logic             req1_pending,
    input  logic             req1_enq__ENA,
    input  logic [WIDTH-1:0] req1_enq_v,
    output logic             req1_enq__RDY,
    output logic             fifo_enq__ENA,
    output logic [WIDTH-1:0] fifo_enq_v,
    input  logic             fifo_enq__RDY
`ifdef FIFO_PONG_ARB_STATS_EN
   ,output logic [STAT_W-1:0] stat_grant0,
    output logic [STAT_W-1:0] stat_grant1,
    output logic [STAT_W-1:0] stat_stall
`endif
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_last_grant;

    logic w_pick_valid;
    logic w_pick;
    logic w_drain;
    logic w_accept;
    logic w_rdy0;
    logic w_rdy1;
    logic w_ena0;
    logic w_ena1;

    arb_rr2 u_arb (
        .i_pending0   (req0_pending),
        .i_pending1   (req1_pending),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_pick       (w_pick)
    );

    // Handshake decode. RDY never looks at ENA, so there is no ENA->RDY loop.
    // Both RDYs and the FIFO strobe are held low while nRST is low so nothing
    // is handed over in a cycle whose state is about to be discarded.
    always_comb begin
        w_drain  = r_out_valid & fifo_enq__RDY;
        w_accept = ~r_out_valid | fifo_enq__RDY;
        w_rdy0   = nRST & w_accept & req0_pending & w_pick_valid & (w_pick == SRC_REQ0);
        w_rdy1   = nRST & w_accept & req1_pending & w_pick_valid & (w_pick == SRC_REQ1);
        w_ena0   = req0_enq__ENA & w_rdy0;
        w_ena1   = req1_enq__ENA & w_rdy1;
    end

    assign req0_enq__RDY = w_rdy0;
    assign req1_enq__RDY = w_rdy1;
    assign fifo_enq__ENA = nRST & r_out_valid;
    assign fifo_enq_v    = r_out_data;

    // Output stage and round-robin state. An accept in the same cycle as a
    // drain simply overwrites the entry, keeping one beat per cycle.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= {WIDTH{1'b0}};
            r_last_grant <= SRC_REQ1;
        end else if (w_ena0) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= req0_enq_v;
            r_last_grant <= SRC_REQ0;
        end else if (w_ena1) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= req1_enq_v;
            r_last_grant <= SRC_REQ1;
        end else if (w_drain) begin
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid  <= r_out_valid;
        end
    end

`ifdef FIFO_PONG_ARB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [STAT_W-1:0] r_grant0;
    logic [STAT_W-1:0] r_grant1;
    logic [STAT_W-1:0] r_stall;
    logic              w_stall;

    assign w_stall = r_out_valid & ~fifo_enq__RDY;

    // Saturating statistics counters.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_grant0 <= {STAT_W{1'b0}};
            r_grant1 <= {STAT_W{1'b0}};
            r_stall  <= {STAT_W{1'b0}};
        end else begin
            if (w_ena0 && (r_grant0 != STAT_MAX)) begin
                r_grant0 <= r_grant0 + STAT_ONE;
            end
            if (w_ena1 && (r_grant1 != STAT_MAX)) begin
                r_grant1 <= r_grant1 + STAT_ONE;
            end
            if (w_stall && (r_stall != STAT_MAX)) begin
                r_stall <= r_stall + STAT_ONE;
            end
        end
    end

    assign stat_grant0 = r_grant0;
    assign stat_grant1 = r_grant1;
    assign stat_stall  = r_stall;
`endif

endmodule

// File: tb/tb_fifo_pong_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_pong_arbiter
// Directed bench for fifo_pong_arbiter: single beat latency, strict
// alternation, back-pressure hold, withheld grant, drain+accept in one cycle,
// and reset in the middle of a held beat.
// -----------------------------------------------------------------------------
module tb_fifo_pong_arbiter;

    localparam int W = 704;

    logic         clk;
    logic         nRST;
    logic         pend0, ena0, rdy0;
    logic         pend1, ena1, rdy1;
    logic [W-1:0] v0, v1;
    logic         f_ena, f_rdy;
    logic [W-1:0] f_v;
`ifdef FIFO_PONG_ARB_STATS_EN
    logic [15:0]  st_g0, st_g1, st_stall;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int n_enq   = 0;
    logic [W-1:0] exp_prev;

    fifo_pong_arbiter dut (
        .CLK           (clk),
        .nRST          (nRST),
        .req0_pending  (pend0),
        .req0_enq__ENA (ena0),
        .req0_enq_v    (v0),
        .req0_enq__RDY (rdy0),
        .req1_pending  (pend1),
        .req1_enq__ENA (ena1),
        .req1_enq_v    (v1),
        .req1_enq__RDY (rdy1),
        .fifo_enq__ENA (f_ena),
        .fifo_enq_v    (f_v),
        .fifo_enq__RDY (f_rdy)
`ifdef FIFO_PONG_ARB_STATS_EN
       ,.stat_grant0   (st_g0),
        .stat_grant1   (st_g1),
        .stat_stall    (st_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count beats the FIFO actually takes.
    always @(posedge clk) begin
        if (nRST && f_ena && f_rdy) n_enq <= n_enq + 1;
    end

    function automatic logic [W-1:0] pl(input logic [7:0] b);
        return {b, {(W-16){1'b0}}, b};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        pend0 = 1'b0; ena0 = 1'b0; v0 = '0;
        pend1 = 1'b0; ena1 = 1'b0; v1 = '0;
        f_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nRST = 1'b1;
    endtask

    initial begin
        do_reset();
        #1;
        check("rst_fifo_ena", f_ena, 1'b0);
        check("rst_fifo_v",   f_v,   '0);
        check("rst_rdy0",     rdy0,  1'b0);
        check("rst_rdy1",     rdy1,  1'b0);

        // Single beat from req0, one cycle latency.
        pend0 = 1'b1; ena0 = 1'b1; v0 = pl(8'hA5); f_rdy = 1'b1;
        #1;
        check("t1_rdy0", rdy0, 1'b1);
        check("t1_rdy1", rdy1, 1'b0);
        @(posedge clk); #1;
        pend0 = 1'b0; ena0 = 1'b0;
        check("t1_fifo_ena", f_ena, 1'b1);
        check("t1_fifo_v",   f_v,   pl(8'hA5));
        @(posedge clk); #1;
        check("t1_drained", f_ena, 1'b0);

        // Both pending continuously: strict alternation starting at req0.
        do_reset();
        pend0 = 1'b1; pend1 = 1'b1; ena0 = 1'b1; ena1 = 1'b1; f_rdy = 1'b1;
        exp_prev = '0;
        for (int i = 0; i < 8; i++) begin
            v0 = pl(8'h10 + 8'(i));
            v1 = pl(8'h20 + 8'(i));
            #1;
            check("t2_rdy0", rdy0, ((i % 2) == 0));
            check("t2_rdy1", rdy1, ((i % 2) == 1));
            if (i > 0) begin
                check("t2_fifo_ena", f_ena, 1'b1);
                check("t2_fifo_v",   f_v,   exp_prev);
            end
            exp_prev = ((i % 2) == 0) ? v0 : v1;
            @(posedge clk); #1;
        end
        check("t2_last_v", f_v, pl(8'h27));

        // Back-pressure for 5 cycles: beat held, both RDYs low.
        pend1 = 1'b0; ena1 = 1'b0;
        pend0 = 1'b1; ena0 = 1'b1; v0 = pl(8'h55);
        f_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_rdy0",     rdy0,  1'b0);
            check("t3_rdy1",     rdy1,  1'b0);
            check("t3_fifo_ena", f_ena, 1'b1);
            check("t3_hold_v",   f_v,   pl(8'h27));
            @(posedge clk); #1;
        end
`ifdef FIFO_PONG_ARB_STATS_EN
        check("t3_stat_stall", st_stall, 16'd5);
`endif
        // Drain of beat 0x27 and accept of 0x55 in the same cycle.
        f_rdy = 1'b1;
        #1;
        check("t3_dra_rdy0", rdy0, 1'b1);
        @(posedge clk); #1;
        check("t3_dra_ena", f_ena, 1'b1);
        check("t3_dra_v",   f_v,   pl(8'h55));
`ifdef FIFO_PONG_ARB_STATS_EN
        check("t3_stat_g0", st_g0, 16'd5);
        check("t3_stat_g1", st_g1, 16'd4);
`endif

        // Tie after req0 won: req1 is granted but withholds ENA for 3 cycles.
        pend0 = 1'b1; pend1 = 1'b1; ena0 = 1'b0; ena1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_hold_rdy1", rdy1, 1'b1);
            check("t4_hold_rdy0", rdy0, 1'b0);
            @(posedge clk); #1;
            check("t4_idle_ena", f_ena, 1'b0);
        end
        ena1 = 1'b1; v1 = pl(8'h77);
        #1;
        check("t4_take_rdy1", rdy1, 1'b1);
        @(posedge clk); #1;
        check("t4_take_v", f_v, pl(8'h77));
        ena1 = 1'b0; ena0 = 1'b1; v0 = pl(8'h66);
        #1;
        check("t4_next_rdy0", rdy0, 1'b1);
        check("t4_next_rdy1", rdy1, 1'b0);
        @(posedge clk); #1;
        check("t4_next_v", f_v, pl(8'h66));

        // Reset while a beat is held.
        pend0 = 1'b0; pend1 = 1'b0; ena0 = 1'b0; ena1 = 1'b0; f_rdy = 1'b0;
        @(posedge clk); #1;
        check("t5_held_ena", f_ena, 1'b1);
        nRST = 1'b0;
        #1;
        check("t5_rstcyc_ena", f_ena, 1'b0);
        @(posedge clk); #1;
        nRST = 1'b1;
        #1;
        check("t5_after_ena", f_ena, 1'b0);
        check("t5_after_v",   f_v,   '0);
`ifdef FIFO_PONG_ARB_STATS_EN
        check("t5_stat_g0",    st_g0,    16'd0);
        check("t5_stat_g1",    st_g1,    16'd0);
        check("t5_stat_stall", st_stall, 16'd0);
`endif
        pend0 = 1'b1; pend1 = 1'b1; ena0 = 1'b1; ena1 = 1'b1; f_rdy = 1'b1;
        v0 = pl(8'h88); v1 = pl(8'h99);
        #1;
        check("t5_tie_rdy0", rdy0, 1'b1);
        check("t5_tie_rdy1", rdy1, 1'b0);
        @(posedge clk); #1;
        check("t5_tie_ena", f_ena, 1'b1);
        check("t5_tie_v",   f_v,   pl(8'h88));
        check("enq_count",  32'(n_enq), 32'd11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
